bt_txpy_seq: RTL
================

Name: bt_txpy_seq

Overview:
Parametrised transmit payload sequencer for the BR/EDR baseband. It fetches payload words from a payload buffer through a prefetch handshake and serialises them LSB first. It appends CRC-16, applies data whitening, and encodes with no FEC, FEC 1/3 or FEC 2/3, emitting one coded bit per bit strobe.
Sits between the TX payload buffer and the modulator bit path. It generalises the FHS-only payload bit path to arbitrary payload types and word widths.

Parameters:
LEN_W, 13, width of payload length in bits (max payload bits = 2^LEN_W-1)
DATA_W, 8, payload buffer word width in bits (power of 2, 8..32)
ADDR_W, 10, payload buffer word address width

Ports:
clk_6M  in  1  system clock, 6 MHz
rstz  in  1  reset, asynchronous, active-low
start_p  in  1  one-cycle pulse: start payload; ignored unless IDLE
abort_p  in  1  one-cycle pulse: abandon payload, return to IDLE
bit_p  in  1  bit-slot strobe (1/0.5/0.33 us); minimum spacing 2 cycles
pylenbit  in  LEN_W  payload length in bits, excluding CRC; sampled at start_p
crc_en  in  1  append CRC-16; sampled at start_p
fec_mode  in  2  0 none, 1 FEC1/3, 2 FEC2/3, 3 treated as none; sampled at start_p
crc_init  in  8  CRC seed (UAP); sampled at start_p
whiten_en  in  1  whitening enable; sampled at start_p
whiten_init  in  7  whitening LFSR seed; sampled at start_p
rd_req  out  1  level: request word at rd_addr
rd_addr  out  ADDR_W  word index, 0 at start
rd_ack  in  1  one-cycle pulse: rd_data valid, request served
rd_data  in  DATA_W  payload word
txbit  out  1  coded output bit
txbit_vld  out  1  pulse: txbit updated
py_period  out  1  high from start acceptance until end/abort
py_endp  out  1  pulse with the final txbit_vld
underrun  out  1  sticky: data bit needed but word not available

Behaviour:
- Reset: all outputs 0; FSM IDLE; all counters, LFSRs and word buffers cleared.
- L = pylenbit + (crc_en ? 16 : 0), computed LEN_W+1 bits wide.
- start_p with L==0: ignored, no py_period, no endp.
- FSM states:
  - IDLE: on start_p with L>0, latch config, seed CRC = {8'h00, crc_init} and whitening LFSR = whiten_init, set py_period, go to FETCH.
  - FETCH: rd_req=1 at rd_addr=0; on rd_ack load current word, go to RUN. bit_p in FETCH is ignored.
  - RUN: on each bit_p emit one coded bit. txbit and txbit_vld are registered, so latency is 1 cycle after bit_p.
  - After the last coded bit: py_endp=1 with that txbit_vld; py_period clears the next cycle; return to IDLE.
- Info stream, index k = 0..Kpad-1, consumed by the encoder:
  - k < pylenbit: data bit k (word k/DATA_W, bit k%DATA_W). CRC updated with this bit.
  - pylenbit <= k < L: CRC register bit 15 first, shifting.
  - k >= L (FEC2/3 only): zero pad up to the next multiple of 10; pad bits are not whitened.
- CRC: x^16+x^12+x^5+1, serial, computed over unwhitened data.
- Whitening: g(D)=D^7+D^4+1. LFSR advances once per whitened info bit; applied to data and CRC bits when whiten_en=1.
- FEC none: 1 coded bit per info bit; total L.
- FEC1/3: each info bit output 3 times; total 3L.
- FEC2/3: per 10-info-bit block, the 10 bits are output as they enter the (15,10) encoder, g(D)=D^5+D^4+D^2+1, then 5 parity bits, MSB first; encoder cleared per block. Total 15*ceil(L/10).
- Prefetch:
  - rd_req is asserted while the next-word register is empty and further words remain, with rd_addr = next index.
  - The next word is promoted to current when the current word is exhausted.
  - rd_req deasserts the cycle after rd_ack.
  - rd_ack outside a request is ignored.
- Underrun: data bit needed at bit_p and word not present -> underrun=1 (sticky until next accepted start_p). Bit 0 is used and the sequence continues.
- abort_p in any state:
  - Next cycle: IDLE, py_period=0, rd_req=0, no endp.
  - abort_p beats start_p and bit_p in the same cycle.
  - A later rd_ack is ignored.
- start_p while not IDLE: ignored.
- Simultaneous bit_p and rd_ack: word load happens first, so the bit uses the new word.

Decomposition:
- Shared package bt_pkg:
  - fec_mode encodings
  - CRC polynomial 16'h1021
  - whitening taps
  - FEC2/3 generator 5'b10101 and block sizes 10/15
- Sub-module bt_fec23_enc: (15,10) serial parity LFSR with clear, shift-in and parity shift-out.
- CRC and whitening stay inline.

Test Plan:
- pylenbit=8, rd_data=8'hA5, crc_en=0, fec_mode=0, whiten_en=0 -> txbit 1,0,1,0,0,1,0,1; py_endp with 8th txbit_vld.
- Same data, fec_mode=1 -> 24 bits 111,000,111,000,000,111,000,111; endp on 24th.
- Data all zero, crc_en=0, whiten_en=0, fec_mode=2:
  - pylenbit=10 -> 15 zeros.
  - pylenbit=11 -> 30 bits, 9 pad zeros.
- pylenbit=144, crc_en=1, crc_init=8'h47, fec_mode=2, whiten_en=1 -> L=160, 18 rd_ack words, 240 coded bits; output matches the golden model; endp on 240th.
- rd_ack withheld past a word boundary -> underrun=1, zero substituted; next start_p clears underrun.
- abort_p after 37 bits, concurrent with bit_p -> no txbit_vld, py_period=0 next cycle, no endp; new start_p runs cleanly.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared BR/EDR baseband constants for the TX payload path: FEC mode encodings,
// CRC-16 and whitening polynomials, and the (15,10) shortened Hamming code.
package bt_pkg;

  typedef enum logic [1:0] {
    FEC_NONE = 2'd0,
    FEC_13   = 2'd1,
    FEC_23   = 2'd2,
    FEC_RSVD = 2'd3
  } fec_mode_e;

  typedef struct packed {
    fec_mode_e fec;
    logic      wen;
  } txpy_cfg_t;

  localparam logic [15:0] CRC_POLY  = 16'h1021;
  // g(D)=D^7+D^4+1: the D^7 bit recirculates into stage 0 and is folded into stage 4
  localparam logic [6:0]  WHT_TAPS  = 7'h10;
  localparam logic [4:0]  FEC23_GEN = 5'b10101;
  localparam logic [3:0]  FEC23_K   = 4'd10;
  localparam logic [3:0]  FEC23_N   = 4'd15;

  function automatic logic [6:0] wht_next(input logic [6:0] s);
    return {s[5:0], s[6]} ^ (s[6] ? WHT_TAPS : 7'h00);
  endfunction

endpackage

// File: rtl/bt_txpy_seq_if.sv
// Payload buffer read port: level request with word address, one-cycle ack with data.
interface bt_txpy_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, rd_addr, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/bt_fec23_enc.sv
// Serial (15,10) parity generator: shift in 10 info bits, then shift the 5 parity
// bits out MSB first from par.
module bt_fec23_enc
  import bt_pkg::*;
(
  input  logic clk_6M,
  input  logic rstz,
  input  logic clr,
  input  logic shift_in,
  input  logic din,
  input  logic shift_out,
  output logic par
);

  logic [4:0] r;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)          r <= '0;
    else if (clr)       r <= '0;
    else if (shift_in)  r <= {r[3:0], 1'b0} ^ ({5{din ^ r[4]}} & FEC23_GEN);
    else if (shift_out) r <= {r[3:0], 1'b0};
  end

  assign par = r[4];

endmodule

// File: rtl/bt_txpy_seq.sv
// BR/EDR TX payload sequencer: prefetches payload words, serialises LSB first,
// appends CRC-16, whitens, and FEC-encodes one coded bit per bit strobe.
module bt_txpy_seq
  import bt_pkg::*;
#(
  parameter int LEN_W  = 13,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             start_p,
  input  logic             abort_p,
  input  logic             bit_p,
  input  logic [LEN_W-1:0] pylenbit,
  input  logic             crc_en,
  input  logic [1:0]       fec_mode,
  input  logic [7:0]       crc_init,
  input  logic             whiten_en,
  input  logic [6:0]       whiten_init,
  bt_txpy_seq_if.master    bus,
  output logic             txbit,
  output logic             txbit_vld,
  output logic             py_period,
  output logic             py_endp,
  output logic             underrun
);

  localparam int KW = LEN_W + 1;
  localparam int BW = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]        state;
  txpy_cfg_t         cfg_q;
  logic [LEN_W-1:0]  pylen_q;
  logic [KW-1:0]     len_q, nwords_q, k;
  logic [1:0]        rep;
  logic [3:0]        pos;
  logic              rep_bit;
  logic [15:0]       crc;
  logic [6:0]        lfsr;
  logic [DATA_W-1:0] cur_word, nxt_word;
  logic              cur_vld, nxt_vld;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic [KW-1:0]     len_in, nwords_in, pylen_x;
  logic              start_acc, ack_ok, step, need_info, in_data, in_crc, wht_on;
  logic              dbit, info, cbit, last, exhaust, ur_set, enc_par;
  logic [BW-1:0]     bidx;
  logic              ecur_vld, enxt_vld, cur_vld_n, nxt_vld_n, req_n;
  logic [DATA_W-1:0] ecur_word, enxt_word, cur_word_n, nxt_word_n;
  logic [ADDR_W-1:0] addr_n;
  logic              is13, is23;

  assign bus.rd_req  = req_q;
  assign bus.rd_addr = addr_q;

  assign len_in    = {1'b0, pylenbit} + (crc_en ? KW'(16) : KW'(0));
  assign nwords_in = ({1'b0, pylenbit} + KW'(DATA_W - 1)) >> BW;
  assign start_acc = (state == ST_IDLE) && start_p && !abort_p && (len_in != '0);
  assign ack_ok    = bus.rd_ack && req_q && (state != ST_IDLE) && !abort_p;
  assign step      = bit_p && (state == ST_RUN) && !abort_p;
  assign is13      = (cfg_q.fec == FEC_13);
  assign is23      = (cfg_q.fec == FEC_23);
  assign pylen_x   = {1'b0, pylen_q};
  assign bidx      = k[BW-1:0];

  always_comb begin
    // a word acked this cycle is visible to a bit consumed in the same cycle
    ecur_vld  = cur_vld | (ack_ok & ~cur_vld);
    ecur_word = cur_vld ? cur_word : bus.rd_data;
    enxt_vld  = nxt_vld | (ack_ok & cur_vld);
    enxt_word = nxt_vld ? nxt_word : bus.rd_data;

    need_info = step && (is13 ? (rep == 2'd0) : is23 ? (pos < FEC23_K) : 1'b1);
    in_data   = (k < pylen_x);
    in_crc    = !in_data && (k < len_q);
    dbit      = ecur_vld & ecur_word[bidx];
    wht_on    = cfg_q.wen & (in_data | in_crc);
    info      = (in_data ? dbit : (in_crc & crc[15])) ^ (wht_on & lfsr[6]);
    ur_set    = need_info && in_data && !ecur_vld;
    exhaust   = need_info && in_data && ((bidx == '1) || (k == pylen_x - KW'(1)));

    cbit = info;
    last = (k == len_q - KW'(1));
    if (is13) begin
      cbit = (rep == 2'd0) ? info : rep_bit;
      last = (rep == 2'd2) && (k == len_q);
    end else if (is23) begin
      cbit = (pos < FEC23_K) ? info : enc_par;
      last = (pos == FEC23_N - 4'd1) && (k >= len_q);
    end

    if (exhaust) begin
      cur_vld_n  = enxt_vld;
      cur_word_n = enxt_word;
      nxt_vld_n  = 1'b0;
      nxt_word_n = enxt_word;
    end else begin
      cur_vld_n  = ecur_vld;
      cur_word_n = ecur_word;
      nxt_vld_n  = enxt_vld;
      nxt_word_n = enxt_word;
    end
    addr_n = addr_q + ADDR_W'(ack_ok);
    // drop the request for one cycle after every ack
    req_n  = !ack_ok && !nxt_vld_n && (32'(addr_n) < 32'(nwords_q));
  end

  bt_fec23_enc u_enc (
    .clk_6M    (clk_6M),
    .rstz      (rstz),
    .clr       (start_acc || abort_p || (step && is23 && (pos == FEC23_N - 4'd1))),
    .shift_in  (need_info && is23),
    .din       (info),
    .shift_out (step && is23 && (pos >= FEC23_K)),
    .par       (enc_par)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state     <= ST_IDLE;
      cfg_q     <= '0;
      pylen_q   <= '0;
      len_q     <= '0;
      nwords_q  <= '0;
      k         <= '0;
      rep       <= '0;
      pos       <= '0;
      rep_bit   <= 1'b0;
      crc       <= '0;
      lfsr      <= '0;
      cur_word  <= '0;
      nxt_word  <= '0;
      cur_vld   <= 1'b0;
      nxt_vld   <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      txbit     <= 1'b0;
      txbit_vld <= 1'b0;
      py_period <= 1'b0;
      py_endp   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      txbit_vld <= step;
      py_endp   <= step && last;
      if (step) txbit <= cbit;

      if (abort_p) begin
        state     <= ST_IDLE;
        py_period <= 1'b0;
        req_q     <= 1'b0;
        cur_vld   <= 1'b0;
        nxt_vld   <= 1'b0;
      end else if (start_acc) begin
        state     <= ST_FETCH;
        cfg_q     <= '{fec: ((fec_mode == FEC_13) || (fec_mode == FEC_23)) ?
                           fec_mode_e'(fec_mode) : FEC_NONE,
                       wen: whiten_en};
        pylen_q   <= pylenbit;
        len_q     <= len_in;
        nwords_q  <= nwords_in;
        k         <= '0;
        rep       <= '0;
        pos       <= '0;
        crc       <= {8'h00, crc_init};
        lfsr      <= whiten_init;
        cur_vld   <= 1'b0;
        nxt_vld   <= 1'b0;
        addr_q    <= '0;
        req_q     <= (nwords_in != '0);
        py_period <= 1'b1;
        underrun  <= 1'b0;
      end else begin
        if (py_endp) py_period <= 1'b0;
        if (state != ST_IDLE) begin
          cur_vld  <= cur_vld_n;
          cur_word <= cur_word_n;
          nxt_vld  <= nxt_vld_n;
          nxt_word <= nxt_word_n;
          addr_q   <= addr_n;
          req_q    <= (step && last) ? 1'b0 : req_n;
          if (ur_set) underrun <= 1'b1;

          if (state == ST_FETCH && (nwords_q == '0 || ack_ok)) state <= ST_RUN;
          if (step && last) state <= ST_IDLE;

          if (need_info) begin
            k <= k + KW'(1);
            if (in_data)
              crc <= {crc[14:0], 1'b0} ^ ({16{crc[15] ^ dbit}} & CRC_POLY);
            else if (in_crc)
              crc <= {crc[14:0], 1'b0};
            if (wht_on) lfsr <= wht_next(lfsr);
          end

          if (step && is13) begin
            rep <= (rep == 2'd2) ? 2'd0 : rep + 2'd1;
            if (rep == 2'd0) rep_bit <= info;
          end
          if (step && is23) pos <= (pos == FEC23_N - 4'd1) ? 4'd0 : pos + 4'd1;
        end
      end
    end
  end

endmodule
